countdown_ctrl: RTL

Sequences a 3-2-1-GO countdown overlay on the 640x480 VGA frame.
- Advances one digit per FRAMES_PER_DIGIT refresh ticks.
- Animates each digit sliding down from Y_START to Y_FINAL.
- Gates the per-pixel sprite output from a 32x16 glyph ROM.
- Sits beside the score and logo layers; its pixel_on/rgb feed the top-level RGB priority mux.

---
 rtl/countdown_pkg.sv | 17 +
 rtl/digit_glyph_rom.sv | 43 ++++
 rtl/countdown_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared constants for the 3-2-1-GO countdown overlay: FSM encodings,
// glyph colours and glyph geometry.
package countdown_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHOW   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [2:0] RGB_RED = 3'b100;
    localparam logic [2:0] RGB_YEL = 3'b110;
    localparam logic [2:0] RGB_BLU = 3'b001;
    localparam logic [2:0] RGB_GRN = 3'b010;

    localparam int GLYPH_W = 32;
    localparam int GLYPH_H = 16;

endpackage

// File: rtl/digit_glyph_rom.sv
// 32x16 glyph ROM for "3", "2", "1" and "GO"; bit 31 is the leftmost pixel.
module digit_glyph_rom (
    input  logic [1:0]  digit,
    input  logic [3:0]  row,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (digit)
            2'd3: case (row)
                4'd1, 4'd2, 4'd12, 4'd13:       word = 32'h0FFF_FFF0;
                4'd6, 4'd7:                     word = 32'h03FF_FFF0;
                4'd3, 4'd4, 4'd5,
                4'd8, 4'd9, 4'd10, 4'd11:       word = 32'h0000_00F0;
                default:                        word = '0;
            endcase
            2'd2: case (row)
                4'd1, 4'd2, 4'd7, 4'd8,
                4'd13, 4'd14:                   word = 32'h0FFF_FFF0;
                4'd3, 4'd4, 4'd5, 4'd6:         word = 32'h0000_00F0;
                4'd9, 4'd10, 4'd11, 4'd12:      word = 32'h0F00_0000;
                default:                        word = '0;
            endcase
            2'd1: case (row)
                4'd2, 4'd3:                     word = 32'h0007_F800;
                4'd13, 4'd14:                   word = 32'h003F_FC00;
                4'd1, 4'd4, 4'd5, 4'd6, 4'd7,
                4'd8, 4'd9, 4'd10, 4'd11, 4'd12: word = 32'h0001_F800;
                default:                        word = '0;
            endcase
            default: case (row)
                // "G" in the left half, "O" in the right half
                4'd1, 4'd2, 4'd12, 4'd13:       word = 32'h3FFC_3FFC;
                4'd3, 4'd4, 4'd5:               word = 32'h3C00_3C3C;
                4'd6, 4'd7:                     word = 32'h3C7C_3C3C;
                4'd8, 4'd9, 4'd10, 4'd11:       word = 32'h3C3C_3C3C;
                default:                        word = '0;
            endcase
        endcase
    end

endmodule

// File: rtl/countdown_ctrl.sv
// 3-2-1-GO countdown overlay: digit sequencing per refresh tick, sliding
// sprite animation and per-pixel glyph gating for the RGB priority mux.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int FRAMES_PER_DIGIT = 60,
    parameter int X_POS            = 300,
    parameter int Y_START          = 0,
    parameter int Y_FINAL          = 10,
    parameter int DROP_STEP        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       refr_tick,
    input  logic       video_on,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       busy,
    output logic       done,
    output logic [1:0] digit,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       pixel_on,
    output logic [2:0] rgb
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_DIGIT - 1);
    localparam logic [9:0] Y_START_V  = 10'(Y_START);
    localparam logic [9:0] Y_FINAL_V  = 10'(Y_FINAL);

    logic [1:0]  state;
    logic [7:0]  frame_cnt;
    logic [10:0] y_step;
    logic [9:0]  y_next;

    // Saturating drop computed one bit wider so a large step cannot wrap.
    assign y_step = {1'b0, sprite_y} + 11'(DROP_STEP);
    assign y_next = (y_step > {1'b0, Y_FINAL_V}) ? Y_FINAL_V : y_step[9:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            digit     <= 2'd0;
            frame_cnt <= 8'd0;
            sprite_y  <= Y_START_V;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SHOW;
                        digit     <= 2'd3;
                        frame_cnt <= 8'd0;
                        sprite_y  <= Y_START_V;
                    end
                end
                ST_SHOW: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        digit     <= 2'd0;
                        frame_cnt <= 8'd0;
                        sprite_y  <= Y_START_V;
                    end else if (refr_tick) begin
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt <= 8'd0;
                            sprite_y  <= Y_START_V;
                            if (digit != 2'd0) digit <= digit - 2'd1;
                            else               state <= ST_FINISH;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                            sprite_y  <= y_next;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    digit     <= 2'd0;
                    frame_cnt <= 8'd0;
                    sprite_y  <= Y_START_V;
                end
            endcase
        end
    end

    assign busy     = (state == ST_SHOW) || (state == ST_FINISH);
    assign done     = (state == ST_FINISH);
    assign sprite_x = 10'(X_POS);

    logic [10:0] x_end, y_end;
    logic        in_box;
    logic [4:0]  col;
    logic [3:0]  row;
    logic [31:0] glyph_word;

    assign x_end  = {1'b0, sprite_x} + 11'(GLYPH_W - 1);
    assign y_end  = {1'b0, sprite_y} + 11'(GLYPH_H - 1);
    assign in_box = (pix_x >= sprite_x) && ({1'b0, pix_x} <= x_end) &&
                    (pix_y >= sprite_y) && ({1'b0, pix_y} <= y_end);
    assign col    = 5'(pix_x - sprite_x);
    assign row    = 4'(pix_y - sprite_y);

    digit_glyph_rom u_rom (
        .digit (digit),
        .row   (row),
        .word  (glyph_word)
    );

    assign pixel_on = busy && video_on && in_box && glyph_word[5'(GLYPH_W - 1) - col];

    always_comb begin
        case (digit)
            2'd3:    rgb = RGB_RED;
            2'd2:    rgb = RGB_YEL;
            2'd1:    rgb = RGB_BLU;
            default: rgb = RGB_GRN;
        endcase
    end

endmodule
